mem_access_unit: RTL
====================

// Module: mem_access_unit
// PURPOSE
//  Memory-side stage directly downstream of the multi-cycle controller. Turns MemRead/MemWrite/IorD/IRWrite
//  into variable-latency bus transactions and owns the Instruction Register (IR) and Memory Data Register (MDR).
//  Asserts mem_stall while a transaction is outstanding; top level gates controller state and PC/register writes with it.
// PARAMETERS
//  ADDR_W    32     address width
//  DATA_W    32     data width
//  TIMEOUT   16     max cycles waiting for mem_ack before abort; 0 = no timeout
//  IR_RST    32'h0  IR reset value
// PORTS
//  clk          in   1       clock, all state on rising edge
//  reset        in   1       asynchronous reset, active-low (0 = reset)
//  MemRead      in   1       controller read request
//  MemWrite     in   1       controller write request
//  IorD         in   1       0: address = PC, 1: address = ALUOut
//  IRWrite      in   1       read result also loads IR
//  PC           in   ADDR_W  instruction address
//  ALUOut       in   ADDR_W  data address
//  WriteData    in   DATA_W  store data (B register)
//  mem_req      out  1       bus request, held until ack
//  mem_we       out  1       bus write enable
//  mem_addr     out  ADDR_W  bus address
//  mem_wdata    out  DATA_W  bus write data
//  mem_rdata    in   DATA_W  bus read data, valid with mem_ack
//  mem_ack      in   1       bus completion, one-cycle pulse
//  Instruction  out  DATA_W  IR contents
//  MDR          out  DATA_W  last read data
//  mem_stall    out  1       access in progress, controller must hold
//  bus_err      out  1       sticky: timeout (or misalignment, see CONFIGURATION)
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, Instruction=IR_RST, MDR=0,
//   mem_stall=0, bus_err=0, timeout counter=0. Reset mid-transaction drops mem_req immediately, no IR/MDR update.
//  FSM IDLE -> WAIT -> DONE -> IDLE.
//  IDLE: if MemRead|MemWrite: latch addr = IorD ? ALUOut : PC, we = MemWrite, wdata = WriteData,
//   ir_ld = IRWrite & ~MemWrite; go WAIT. mem_stall is combinationally 1 in this cycle (request seen).
//  WAIT: mem_req=1, address/data/we held stable. mem_stall=1. Counter increments each cycle.
//   mem_ack=1: read -> MDR<=mem_rdata; if ir_ld, Instruction<=mem_rdata; go DONE; mem_req drops next cycle.
//   counter==TIMEOUT-1 with no ack (TIMEOUT!=0): abort, mem_req=0, bus_err<=1, MDR/IR unchanged, go DONE.
//   ack in the same cycle as timeout: ack wins, no error.
//  DONE: mem_stall=0 for exactly one cycle so controller advances; no new request this cycle; go IDLE.
//  Latency: request-seen to stall release = (ack delay)+2 cycles; zero-wait ack (ack first WAIT cycle) = 2 stall cycles.
//  MemRead & MemWrite both high: write performed, no read data captured, IR not loaded.
//  Requests changing while in WAIT are ignored (latched copy used). Counter cleared on entering WAIT.
//  bus_err clears only on reset. Instruction/MDR hold value between accesses.
// CONFIGURATION
//  MEM_ALIGN_CHK_EN defined: in IDLE, a request whose address[1:0]!=0 issues no bus request; bus_err<=1,
//   IR/MDR unchanged, state goes straight to DONE (mem_stall=1 for 1 cycle).
//  Not defined: low address bits passed to the bus unchanged, no alignment check.
// TESTING
//  Fetch: MemRead=1,IorD=0,IRWrite=1,PC=0x40, ack after 3 cycles with rdata=0x8C220004 -> mem_addr=0x40,
//   Instruction=MDR=0x8C220004, stall for 5 cycles then 1 cycle low.
//  Load: MemRead=1,IorD=1,IRWrite=0,ALUOut=0x1000, rdata=0xDEADBEEF -> MDR=0xDEADBEEF, Instruction unchanged.
//  Store: MemWrite=1,IorD=1,ALUOut=0x2004,WriteData=0x12345678 -> mem_we=1, mem_wdata=0x12345678 held until ack, MDR unchanged.
//  Timeout: TIMEOUT=16, never ack -> mem_req drops after 16 WAIT cycles, bus_err=1, stall releases next cycle.
//  Reset mid-WAIT: reset=0 two cycles after request -> mem_req=0 immediately, Instruction=IR_RST, bus_err=0.
//  MEM_ALIGN_CHK_EN: MemRead,IorD=1,ALUOut=0x1002 -> mem_req never asserted, bus_err=1, stall 1 cycle.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory access stage: turns controller MemRead/MemWrite into variable-latency bus transactions, owns IR and MDR.
// Optional build macro MEM_ALIGN_CHK_EN rejects word-misaligned requests with a sticky bus error.
module mem_access_unit #(
  parameter int                ADDR_W  = 32,
  parameter int                DATA_W  = 32,
  parameter int                TIMEOUT = 16,
  parameter logic [DATA_W-1:0] IR_RST  = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              IorD,
  input  logic              IRWrite,
  input  logic [ADDR_W-1:0] PC,
  input  logic [ADDR_W-1:0] ALUOut,
  input  logic [DATA_W-1:0] WriteData,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] Instruction,
  output logic [DATA_W-1:0] MDR,
  output logic              mem_stall,
  output logic              bus_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit              TO_EN    = (TIMEOUT != 0);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ir_ld;
  logic               r_mem_req;
  logic               r_mem_we;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [DATA_W-1:0]  r_mem_wdata;
  logic [DATA_W-1:0]  r_ir;
  logic [DATA_W-1:0]  r_mdr;
  logic               r_bus_err;

  logic               w_req;
  logic [ADDR_W-1:0]  w_addr;
  logic               w_misaligned;
  logic               w_timeout;

  assign w_req     = MemRead | MemWrite;
  assign w_addr    = IorD ? ALUOut : PC;
  assign w_timeout = TO_EN && (r_cnt == CNT_LAST);

`ifdef MEM_ALIGN_CHK_EN
  assign w_misaligned = (w_addr[1:0] != 2'b00);
`else
  assign w_misaligned = 1'b0;
`endif

  // Stall is raised combinationally in the cycle the request is first seen.
  assign mem_stall = (r_state == S_WAIT) || ((r_state == S_IDLE) && w_req);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_ir_ld     <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_ir        <= IR_RST;
      r_mdr       <= '0;
      r_bus_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_mem_we    <= MemWrite;
            r_mem_addr  <= w_addr;
            r_mem_wdata <= WriteData;
            r_ir_ld     <= IRWrite & ~MemWrite;
            r_cnt       <= '0;
            if (w_misaligned) begin
              r_bus_err <= 1'b1;
              r_state   <= S_DONE;
            end else begin
              r_mem_req <= 1'b1;
              r_state   <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          // An ack arriving on the timeout cycle takes priority over the abort.
          if (mem_ack) begin
            if (!r_mem_we) begin
              r_mdr <= mem_rdata;
              if (r_ir_ld) r_ir <= mem_rdata;
            end
            r_mem_req <= 1'b0;
            r_state   <= S_DONE;
          end else if (w_timeout) begin
            r_mem_req <= 1'b0;
            r_bus_err <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_req     = r_mem_req;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign Instruction = r_ir;
  assign MDR         = r_mdr;
  assign bus_err     = r_bus_err;

endmodule
